sha256_round_ctrl: RTL

Sequencing controller for the registered SHA-256 round unit. It accepts one 512-bit message block per handshake and owns the working variables a..h, the chaining hash H0..H7 and the 16-word message-schedule window. It drives the round unit for 64 rounds at 2 cycles per round, then folds the result into H and presents a 256-bit digest. It sits between the block-feed logic (padding/nonce insertion) and the round datapath.

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/sha256_round_ctrl_if.sv | 28 ++
 rtl/sha256_msg_sched.sv | 36 +++
 rtl/sha256_round_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and message-schedule helpers.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_CAPTURE,
    ST_FINAL
  } state_e;

  // Initial hash value H0..H7, H0 in the top word.
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Small sigma functions used by the message schedule.
  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Block feed, round-unit and digest signals of the round controller.
// slave = controller side, master = block feed plus round unit.
interface sha256_round_ctrl_if;
  import sha256_pkg::*;

  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic [255:0] rnd_state;
  word_t        rnd_w;
  logic [5:0]   rnd_select;
  word_t        rnd_t1_out;
  word_t        rnd_t2_out;
  logic         digest_valid;
  logic [255:0] digest;

  modport slave (
    input  blk_valid, blk_data, blk_first, rnd_t1_out, rnd_t2_out,
    output blk_ready, rnd_state, rnd_w, rnd_select, digest_valid, digest
  );

  modport master (
    output blk_valid, blk_data, blk_first, rnd_t1_out, rnd_t2_out,
    input  blk_ready, rnd_state, rnd_w, rnd_select, digest_valid, digest
  );

endinterface

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message-schedule window; win[0] is W_t of the current round.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] blk_data,
  output word_t        w
);

  word_t win [16];
  word_t w_next;

  // Next schedule word W_{t+16} computed from the current window.
  always_comb begin
    w_next = s1(win[14]) + win[9] + s0(win[1]) + win[0];
  end

  // Load a block big-endian (word 0 from the top bits) or slide by one round.
  // NOTE: the window is reset like any other register so rnd_w reads 0, not X, straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= blk_data[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i + 1];
      win[15] <= w_next;
    end
  end

  assign w = win[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: accepts a block, runs ROUNDS rounds on the external
// registered round unit at 2 cycles per round, then folds into H.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS  = 64,
  parameter int RND_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  sha256_round_ctrl_if.slave bus
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  if (RND_LAT != 1 || ROUNDS < 1 || ROUNDS > 64) begin : g_bad_cfg
    $error("sha256_round_ctrl: needs RND_LAT == 1 and 1 <= ROUNDS <= 64");
  end

  state_e           state_q, state_d;
  logic [5:0]       t_q;
  logic [0:7][31:0] work_q;  // a..h, a at index 0
  logic [0:7][31:0] h_q;     // H0..H7, H0 at index 0
  logic             dv_q;
  logic             accept, load_work, capture, fold;
  word_t            rnd_w;

  assign bus.blk_ready = (state_q == ST_IDLE);
  assign accept        = bus.blk_ready && bus.blk_valid;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-state control strobes.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load_work = 1'b0;
    capture   = 1'b0;
    fold      = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (bus.blk_valid) state_d = ST_LOAD;
      ST_LOAD: begin
        load_work = 1'b1;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = (t_q == LAST_T) ? ST_FINAL : ST_ISSUE;
      end
      ST_FINAL: begin
        fold    = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Round counter, working variables, chaining hash and digest strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q    <= '0;
      work_q <= '0;
      h_q    <= SHA256_IV;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= fold;
      if (accept && bus.blk_first) h_q <= SHA256_IV;
      if (load_work) begin
        work_q <= h_q;
        t_q    <= '0;
      end
      if (capture) begin
        work_q <= {bus.rnd_t1_out, work_q[0], work_q[1], work_q[2],
                   bus.rnd_t2_out, work_q[4], work_q[5], work_q[6]};
        if (t_q != LAST_T) t_q <= t_q + 6'd1;
      end
      if (fold) begin
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + work_q[i];
      end
    end
  end

  sha256_msg_sched u_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift    (capture),
    .blk_data (bus.blk_data),
    .w        (rnd_w)
  );

  assign bus.rnd_state    = work_q;
  assign bus.rnd_w        = rnd_w;
  assign bus.rnd_select   = t_q;
  assign bus.digest_valid = dv_q;
  assign bus.digest       = h_q;

endmodule
